// File: rtl/sdram_port_arbiter.sv
// Slot-synchronous arbiter sharing the SDRAM controller's byte-wide CPU port between
// three requesters. Define SDRAM_ARB_RR_EN for round-robin; default is fixed priority 0>1>2.
module sdram_port_arbiter #(
  parameter int unsigned GAP_SLOTS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clkref,
  input  logic [2:0]  req,
  input  logic [2:0]  wr,
  input  logic [22:0] addr0,
  input  logic [22:0] addr1,
  input  logic [22:0] addr2,
  input  logic [1:0]  bank0,
  input  logic [1:0]  bank1,
  input  logic [1:0]  bank2,
  input  logic [7:0]  din0,
  input  logic [7:0]  din1,
  input  logic [7:0]  din2,
  output logic [2:0]  ack,
  output logic [7:0]  rdata,
  output logic [22:0] sd_addr,
  output logic [1:0]  sd_bank,
  output logic [7:0]  sd_din,
  output logic        sd_oe,
  output logic        sd_we,
  input  logic [7:0]  sd_dout,
  output logic        busy
);

  typedef enum logic [1:0] {S_SYNC, S_IDLE, S_BUSY, S_GAP} state_t;

  localparam logic [1:0] GAP_LAST = 2'(GAP_SLOTS - 1);

  state_t     state, state_nxt;
  logic       old_ref;
  logic [2:0] ph;
  logic       ref_rise;
  logic       slot_edge;
  logic       busy_end;
  logic       gap_done;
  logic [1:0] gap_cnt;
  logic [1:0] owner;
  logic       win_valid;
  logic [1:0] win_idx;
  logic       grant;

  assign ref_rise  = ~old_ref & clkref;
  // slot_edge marks the edge that takes ph to 0 (natural wrap or clkref re-phase).
  assign slot_edge = ref_rise | (ph == 3'd7);
  assign busy_end  = (state == S_BUSY) && (ph == 3'd7);
  assign gap_done  = (state == S_GAP) && slot_edge && (gap_cnt == GAP_LAST);
  assign grant     = slot_edge && win_valid &&
                     ((state == S_IDLE) || ((state == S_GAP) && (gap_cnt == GAP_LAST)));
  assign busy      = (state == S_BUSY) || (state == S_GAP);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      old_ref <= 1'b0;
      ph      <= 3'd0;
    end else begin
      old_ref <= clkref;
      ph      <= ref_rise ? 3'd0 : ph + 3'd1;
    end
  end

`ifdef SDRAM_ARB_RR_EN
  logic [1:0] rr_ptr;
  logic [1:0] cand;

  function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] off);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, off};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Scan farthest-first so the port nearest rr_ptr overwrites and wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      cand = wrap3(rr_ptr, 2'(i));
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rr_ptr <= 2'd0;
    else if (grant) rr_ptr <= wrap3(win_idx, 2'd1);
  end
`else
  // NOTE: every variable written here gets a value on every path, so no latch is inferred.
  always_comb begin
    win_valid = |req;
    win_idx   = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_SYNC;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_SYNC:  if (ref_rise) state_nxt = S_IDLE;
      S_IDLE:  if (grant)    state_nxt = S_BUSY;
      S_BUSY:  if (busy_end) state_nxt = S_GAP;
      S_GAP: begin
        if (grant)         state_nxt = S_BUSY;
        else if (gap_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack     <= 3'b000;
      rdata   <= 8'h00;
      sd_addr <= '0;
      sd_bank <= 2'd0;
      sd_din  <= 8'h00;
      sd_oe   <= 1'b0;
      sd_we   <= 1'b0;
      owner   <= 2'd0;
      gap_cnt <= 2'd0;
    end else begin
      ack <= 3'b000;
      if (grant) begin
        owner <= win_idx;
        sd_oe <= ~wr[win_idx];
        sd_we <= wr[win_idx];
        case (win_idx)
          2'd0: begin
            sd_addr <= addr0;
            sd_bank <= bank0;
            sd_din  <= din0;
          end
          2'd1: begin
            sd_addr <= addr1;
            sd_bank <= bank1;
            sd_din  <= din1;
          end
          default: begin
            sd_addr <= addr2;
            sd_bank <= bank2;
            sd_din  <= din2;
          end
        endcase
      end
      // Both strobes drop together so the controller sees a fresh rising edge next access.
      if (busy_end) begin
        rdata   <= sd_dout;
        ack     <= 3'b001 << owner;
        sd_oe   <= 1'b0;
        sd_we   <= 1'b0;
        gap_cnt <= 2'd0;
      end else if ((state == S_GAP) && slot_edge) begin
        gap_cnt <= gap_cnt + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed scoreboard bench for sdram_port_arbiter with a small controller/memory model;
// a second instance runs with GAP_SLOTS = 3.
module tb_sdram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clkref;
  logic [2:0]  req, wr, req3;
  logic [22:0] addr0, addr1, addr2;
  logic [1:0]  bank0, bank1, bank2;
  logic [7:0]  din0, din1, din2;
  logic [2:0]  ack, ack3;
  logic [7:0]  rdata, rdata3;
  logic [22:0] sd_addr, sd_addr3;
  logic [1:0]  sd_bank, sd_bank3;
  logic [7:0]  sd_din, sd_din3;
  logic        sd_oe, sd_we, sd_oe3, sd_we3;
  logic [7:0]  sd_dout;
  logic        busy, busy3;

  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .clk(clk), .reset_n(reset_n), .clkref(clkref), .req(req), .wr(wr),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .bank0(bank0), .bank1(bank1), .bank2(bank2),
    .din0(din0), .din1(din1), .din2(din2),
    .ack(ack), .rdata(rdata), .sd_addr(sd_addr), .sd_bank(sd_bank), .sd_din(sd_din),
    .sd_oe(sd_oe), .sd_we(sd_we), .sd_dout(sd_dout), .busy(busy)
  );

  sdram_port_arbiter #(.GAP_SLOTS(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .clkref(clkref), .req(req3), .wr(3'b000),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .bank0(bank0), .bank1(bank1), .bank2(bank2),
    .din0(din0), .din1(din1), .din2(din2),
    .ack(ack3), .rdata(rdata3), .sd_addr(sd_addr3), .sd_bank(sd_bank3), .sd_din(sd_din3),
    .sd_oe(sd_oe3), .sd_we(sd_we3), .sd_dout(sd_dout), .busy(busy3)
  );

  typedef struct {
    logic [1:0] port;
    logic       is_wr;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mem [logic [22:0]];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [2:0] ph_tb = 3'd0;
  logic       ref_en = 1'b0;
  logic       prev_strobe = 1'b0;
  logic       run_valid = 1'b0;
  int         rise_cyc = -1;
  int         fall_cyc = -1;
  int         rise_q[$];
  int         ack_cnt = 0;
  logic       prev_oe3 = 1'b0;
  int         fall3 = -1;
  int         rise3_q[$];
  int         low3_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    logic strobe;
    strobe = sd_oe | sd_we;
    if (reset_n) begin
      if (strobe && !prev_strobe) begin
        check("strobe_phase0", 32'(ph_tb), 0);
        check("strobe_onehot", 32'(sd_oe ^ sd_we), 1);
        rise_cyc  = cyc;
        run_valid = 1'b1;
        rise_q.push_back(cyc);
      end
      if (!strobe && prev_strobe) begin
        if (run_valid) check("strobe_len", cyc - rise_cyc, 8);
        fall_cyc = cyc;
      end
      if (ack != 3'b000) begin
        ack_cnt++;
        if (sb_q.size() == 0) begin
          check("spurious_ack", 32'(ack), 0);
        end else begin
          e = sb_q.pop_front();
          check("ack_port", 32'(ack), 32'(1) << e.port);
          check("ack_latency", cyc - rise_cyc, 8);
          if (!e.is_wr) check("rdata", 32'(rdata), 32'(e.data));
        end
      end
      if (sd_oe3 && !prev_oe3) begin
        rise3_q.push_back(cyc);
        if (fall3 >= 0) low3_q.push_back(cyc - fall3);
      end
      if (!sd_oe3 && prev_oe3) fall3 = cyc;
      prev_strobe = strobe;
      prev_oe3    = sd_oe3;
    end else begin
      prev_strobe = 1'b0;
      prev_oe3    = 1'b0;
      run_valid   = 1'b0;
    end
  endtask

  // One clock: advance the reference phase, run the controller model, then observe.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    ph_tb  = ph_tb + 3'd1;
    clkref = ref_en && (ph_tb == 3'd7);
    if (sd_we && ph_tb == 3'd2) mem[sd_addr] = sd_din;
    sd_dout = (sd_oe && mem.exists(sd_addr)) ? mem[sd_addr] : 8'h00;
    monitor();
  endtask

  task automatic wait_phase(input logic [2:0] p);
    for (int i = 0; i < 9 && ph_tb != p; i++) step();
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int n;
    n = ack_cnt;
    for (int i = 0; i < budget && ack_cnt == n; i++) step();
    check({tag, "_ack_seen"}, 32'(ack_cnt != n), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},     32'(ack), 0);
    check({tag, "_rdata"},   32'(rdata), 0);
    check({tag, "_sd_addr"}, 32'(sd_addr), 0);
    check({tag, "_sd_bank"}, 32'(sd_bank), 0);
    check({tag, "_sd_din"},  32'(sd_din), 0);
    check({tag, "_sd_oe"},   32'(sd_oe), 0);
    check({tag, "_sd_we"},   32'(sd_we), 0);
    check({tag, "_busy"},    32'(busy), 0);
  endtask

  initial begin
    logic [1:0] order [4];
    int n, m, req_cyc, wfall;

    reset_n = 1'b0; clkref = 1'b0; req = 3'b000; wr = 3'b000; req3 = 3'b000;
    addr0 = '0; addr1 = '0; addr2 = '0; bank0 = '0; bank1 = '0; bank2 = '0;
    din0 = '0; din1 = '0; din2 = '0; sd_dout = 8'h00;

    repeat (3) step();
    check_all_zero("rst");
    reset_n = 1'b1;

    // No clkref yet: arbiter stays in SYNC and ignores requests.
    req = 3'b001;
    repeat (20) step();
    check("sync_no_grant", rise_q.size(), 0);
    check("sync_busy", 32'(busy), 0);
    req = 3'b000;
    ref_en = 1'b1;
    repeat (16) step();

    // All three held together from a fresh pointer.
`ifdef SDRAM_ARB_RR_EN
    order = '{2'd0, 2'd1, 2'd2, 2'd0};
`else
    order = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    addr0 = 23'h10; addr1 = 23'h11; addr2 = 23'h12;
    mem[23'h10] = 8'hB0; mem[23'h11] = 8'hB1; mem[23'h12] = 8'hB2;
    wait_phase(3'd5);
    n = rise_q.size();
    req = 3'b111;
    for (int k = 0; k < 4; k++) sb_q.push_back('{port: order[k], is_wr: 1'b0, data: 8'hB0 + 8'(order[k])});
    for (int k = 0; k < 4; k++) wait_ack("all3", 40);
    req = 3'b000;
    check("all3_grant_count", rise_q.size() - n, 4);
    for (int k = n + 1; k < rise_q.size(); k++) check("all3_spacing", rise_q[k] - rise_q[k-1], 16);
    repeat (10) step();

    // Single read raised mid-slot at phase 3.
    mem[23'h012345] = 8'hA5; addr0 = 23'h012345; bank0 = 2'd1;
    wait_phase(3'd3);
    req_cyc = cyc;
    req[0] = 1'b1;
    sb_q.push_back('{port: 2'd0, is_wr: 1'b0, data: 8'hA5});
    wait_ack("rd0", 40);
    req[0] = 1'b0;
    check("midslot_grant_delay", rise_cyc - req_cyc, 5);
    check("rd0_sd_addr", 32'(sd_addr), 32'h012345);
    check("rd0_sd_bank", 32'(sd_bank), 1);
    repeat (12) step();

    // Port 1 write, then keep req high and read it back.
    mem[23'h000100] = 8'h00; addr1 = 23'h000100; bank1 = 2'd3; din1 = 8'h3C;
    wr[1] = 1'b1; req[1] = 1'b1;
    sb_q.push_back('{port: 2'd1, is_wr: 1'b1, data: 8'h00});
    wait_ack("wr1", 40);
    wfall = fall_cyc;
    check("wr1_mem", 32'(mem[23'h000100]), 32'h3C);
    check("wr1_sd_din", 32'(sd_din), 32'h3C);
    wr[1] = 1'b0;
    sb_q.push_back('{port: 2'd1, is_wr: 1'b0, data: 8'h3C});
    wait_ack("rd1", 40);
    req[1] = 1'b0;
    check("wr_rd_gap", rise_cyc - wfall, 8);
    repeat (12) step();

    // Reset in the middle of a read at BUSY phase 4: no ack is expected for it.
    mem[23'h000200] = 8'h77; addr2 = 23'h000200; bank2 = 2'd2;
    req[2] = 1'b1;
    for (int i = 0; i < 40 && !(sd_oe && ph_tb == 3'd4); i++) step();
    check("rst_mid_reached", 32'(sd_oe && ph_tb == 3'd4), 1);
    #1 reset_n = 1'b0;
    #1 check_all_zero("rst_mid");
    ref_en = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    n = rise_q.size();
    m = ack_cnt;
    repeat (24) step();
    check("post_rst_no_grant", rise_q.size() - n, 0);
    check("post_rst_no_ack", ack_cnt - m, 0);
    ref_en = 1'b1;
    sb_q.push_back('{port: 2'd2, is_wr: 1'b0, data: 8'h77});
    wait_ack("post_rst_rd2", 48);
    req[2] = 1'b0;
    check("post_rst_sd_bank", 32'(sd_bank), 2);
    repeat (12) step();

    // GAP_SLOTS = 3 instance with continuous port-2 requests.
    rise3_q.delete(); low3_q.delete(); fall3 = -1;
    req3 = 3'b100;
    for (int i = 0; i < 200 && rise3_q.size() < 3; i++) step();
    req3 = 3'b000;
    check("gap3_accesses", rise3_q.size(), 3);
    for (int k = 1; k < rise3_q.size(); k++) check("gap3_spacing", rise3_q[k] - rise3_q[k-1], 32);
    check("gap3_low_runs", low3_q.size(), 2);
    for (int k = 0; k < low3_q.size(); k++) check("gap3_oe_low", low3_q[k], 24);
    repeat (8) step();
    check("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
